// File: rtl/kmer_pkg.sv
// Shared types and constants for the k-mer extractor: base codes, default
// geometry, the k-mer word type and the capture FSM state encoding.
package kmer_pkg;

  localparam int K_DEF       = 16;
  localparam int SEQ_LEN_DEF = 64;
  localparam int KMER_W_DEF  = 2 * K_DEF;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  typedef logic [KMER_W_DEF-1:0] kmer_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } kmer_state_e;

endpackage

// File: rtl/kmer_extractor_if.sv
// Base-stream input and k-mer array output bundle of the k-mer extractor.
// Handshake: a base moves on a rising edge where baseValid && baseReady; kmersOut
// is stable while kmersValid is high and is released by a kmersAck pulse.
interface kmer_extractor_if #(
  parameter int SEQ_LEN = kmer_pkg::SEQ_LEN_DEF,
  parameter int K       = kmer_pkg::K_DEF
);
  import kmer_pkg::*;

  localparam int KMER_W    = 2 * K;
  localparam int NUM_KMERS = SEQ_LEN - K + 1;

  logic                                 start;
  logic                                 baseValid;
  logic [1:0]                           baseData;
  logic                                 baseReady;
  logic                                 busy;
  logic [NUM_KMERS-1:0][KMER_W-1:0]     kmersOut;
  logic                                 kmersValid;
  logic                                 kmersAck;

  modport master (
    output start, baseValid, baseData, kmersAck,
    input  baseReady, busy, kmersOut, kmersValid
  );

  modport slave (
    input  start, baseValid, baseData, kmersAck,
    output baseReady, busy, kmersOut, kmersValid
  );

endinterface

// File: rtl/kmer_revcomp.sv
// Canonical k-mer select: min(forward, reverse complement) as an unsigned compare.
// The first (most significant) base of fwd becomes the least significant pair of rc.
module kmer_revcomp
  import kmer_pkg::*;
#(
  parameter int K = K_DEF
) (
  input  logic [2*K-1:0] fwd,
  output logic [2*K-1:0] kmer
);

  logic [2*K-1:0] rc;

  always_comb begin
    rc = '0;
    for (int i = 0; i < K; i++) begin
      rc[2*i +: 2] = ~fwd[2*(K-1-i) +: 2];
    end
  end

  assign kmer = (fwd < rc) ? fwd : rc;

endmodule

// File: rtl/kmer_extractor.sv
// Slides a K-base window over one SEQ_LEN-base DNA stream and registers all k-mers.
// Define KMER_CANONICAL_EN to store min(forward, reverse complement) per k-mer.
module kmer_extractor
  import kmer_pkg::*;
#(
  parameter int SEQ_LEN = SEQ_LEN_DEF,
  parameter int K       = K_DEF
) (
  input  logic              clk,
  input  logic              rst,
  kmer_extractor_if.slave   bus,
  output kmer_state_e       dbg_state
);

  localparam int KMER_W    = 2 * K;
  localparam int NUM_KMERS = SEQ_LEN - K + 1;
  localparam int CNT_W     = $clog2(SEQ_LEN + 1);
  localparam int IDX_W     = (NUM_KMERS > 1) ? $clog2(NUM_KMERS) : 1;

  kmer_state_e                       state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q;
  logic [KMER_W-1:0]                 window_q, window_nxt, store_val;
  logic [NUM_KMERS-1:0][KMER_W-1:0]  kmers_q;
  logic                              ready, accept, wr_en, last_base, kth_base;
  logic [IDX_W-1:0]                  wr_idx;

  assign ready      = (state_q == FILL) || (state_q == EMIT);
  assign accept     = bus.baseValid && ready;
  assign last_base  = (cnt_q == CNT_W'(SEQ_LEN - 1));
  assign kth_base   = (cnt_q == CNT_W'(K - 1));
  assign window_nxt = {window_q[KMER_W-3:0], bus.baseData};
  // Once the window is full, base number K+i lands in slot i.
  assign wr_en      = accept && ((state_q == EMIT) || kth_base);
  assign wr_idx     = IDX_W'(cnt_q - CNT_W'(K - 1));

`ifdef KMER_CANONICAL_EN
  kmer_revcomp #(.K(K)) u_revcomp (
    .fwd  (window_nxt),
    .kmer (store_val)
  );
`else
  assign store_val = window_nxt;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = FILL;
      FILL: begin
        if (accept && last_base)     state_d = DONE;
        else if (accept && kth_base) state_d = EMIT;
      end
      EMIT: if (accept && last_base) state_d = DONE;
      DONE: if (bus.kmersAck) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      window_q <= '0;
      kmers_q  <= '0;
    end else if ((state_q == IDLE) && bus.start) begin
      cnt_q    <= '0;
      window_q <= '0;
      kmers_q  <= '0;
    end else if (accept) begin
      cnt_q    <= cnt_q + CNT_W'(1);
      window_q <= window_nxt;
      if (wr_en) kmers_q[wr_idx] <= store_val;
    end
  end

  assign bus.baseReady  = ready;
  assign bus.busy       = ready;
  assign bus.kmersValid = (state_q == DONE);
  assign bus.kmersOut   = kmers_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_kmer_extractor.sv
// Directed bench for kmer_extractor: forward, homopolymer, gapped, reset-abort and
// control-pulse scenarios checked against a k-mer reference model.
module tb_kmer_extractor;
  import kmer_pkg::*;

  localparam int SEQ_LEN   = 64;
  localparam int K         = 16;
  localparam int NUM_KMERS = SEQ_LEN - K + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  kmer_state_e dbg_state;

  kmer_extractor_if #(.SEQ_LEN(SEQ_LEN), .K(K)) bus ();

  kmer_extractor #(.SEQ_LEN(SEQ_LEN), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic [1:0]  seq [SEQ_LEN];
  logic [31:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: bases i..i+K-1 with the earliest base in the top pair
  function automatic kmer_t exp_kmer(input int i);
    kmer_t fwd, rc;
    fwd = '0;
    rc  = '0;
    for (int j = 0; j < K; j++) begin
      fwd[2*(K-1-j) +: 2] = seq[i+j];
      rc[2*j +: 2]        = ~seq[i+j];
    end
`ifdef KMER_CANONICAL_EN
    return (rc < fwd) ? rc : fwd;
`else
    return fwd;
`endif
  endfunction

  task automatic check_array(input string tag);
    exp_q.delete();
    for (int i = 0; i < NUM_KMERS; i++) exp_q.push_back(exp_kmer(i));
    for (int i = 0; i < NUM_KMERS; i++)
      check_eq($sformatf("%s[%0d]", tag, i), bus.kmersOut[i], exp_q.pop_front());
  endtask

  task automatic build_fwd();
    logic [31:0] head;
    head = 32'hC68F8F21;
    for (int j = 0; j < K; j++) seq[j] = head[31-2*j -: 2];
    seq[16] = BASE_T;
    for (int j = 17; j < 48; j++) seq[j] = 2'((j * 5 + j / 3) % 4);
    for (int j = 48; j < SEQ_LEN; j++) seq[j] = (j % 2 == 0) ? BASE_C : BASE_G;
  endtask

  task automatic build_const(input logic [1:0] b);
    for (int j = 0; j < SEQ_LEN; j++) seq[j] = b;
  endtask

  // driver: start pulse then n bases with up to max_gap idle cycles before each;
  // optional stray start / ack pulses before base start_at / ack_at
  task automatic send_seq(input int n, input int max_gap, input int start_at, input int ack_at);
    int gap;
    int guard;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("start_clear", 32'(|bus.kmersOut), 32'd0);
    check_eq("start_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      bus.baseValid = 1'b0;
      if (i == start_at) begin
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
      end
      if (i == ack_at) begin
        bus.kmersAck = 1'b1;
        tick();
        bus.kmersAck = 1'b0;
      end
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) tick();
      bus.baseValid = 1'b1;
      bus.baseData  = seq[i];
      guard = 0;
      while (!bus.baseReady && guard < 20) begin
        tick();
        guard++;
      end
      check_eq($sformatf("ready_base%0d", i), 32'(bus.baseReady), 32'd1);
      if (i == SEQ_LEN - 1) check_eq("valid_before_last", 32'(bus.kmersValid), 32'd0);
      tick();
      bus.baseValid = 1'b0;
    end
    if (n == SEQ_LEN) begin
      check_eq("valid_after_last", 32'(bus.kmersValid), 32'd1);
      check_eq("done_ready", 32'(bus.baseReady), 32'd0);
      check_eq("done_busy", 32'(bus.busy), 32'd0);
      check_eq("done_state", 32'(dbg_state), 32'(DONE));
    end
  endtask

  task automatic ack_done(input string tag);
    bus.kmersAck = 1'b1;
    tick();
    bus.kmersAck = 1'b0;
    check_eq({tag, "_ack_valid"}, 32'(bus.kmersValid), 32'd0);
    check_eq({tag, "_ack_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.baseValid = 1'b0;
    bus.baseData  = BASE_A;
    bus.kmersAck  = 1'b0;

    repeat (2) tick();
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    check_eq("rst_ready", 32'(bus.baseReady), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_valid", 32'(bus.kmersValid), 32'd0);
    check_eq("rst_kmers", 32'(|bus.kmersOut), 32'd0);
    rst = 1'b0;
    tick();

    // forward stream, no gaps
    build_fwd();
    send_seq(SEQ_LEN, 0, -1, -1);
`ifndef KMER_CANONICAL_EN
    check_eq("fwd_k0", bus.kmersOut[0], 32'hC68F8F21);
    check_eq("fwd_k1", bus.kmersOut[1], 32'h1A3E3C87);
`endif
    check_eq("fwd_k48", bus.kmersOut[48], 32'h66666666);
    check_array("fwd");

    // stray start in DONE is ignored and the array holds
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    check_eq("done_start_state", 32'(dbg_state), 32'(DONE));
    check_eq("done_start_valid", 32'(bus.kmersValid), 32'd1);
    check_array("fwd_hold");
    ack_done("fwd");
    check_eq("hold_after_ack", bus.kmersOut[0], exp_kmer(0));

    // gapped stream with stray start and ack mid-capture
    send_seq(SEQ_LEN, 3, 10, 20);
    check_array("bp");
    ack_done("bp");

    // all-T, then simultaneous ack + start in DONE
    build_const(BASE_T);
    send_seq(SEQ_LEN, 0, -1, -1);
`ifdef KMER_CANONICAL_EN
    check_eq("allt_k0", bus.kmersOut[0], 32'h00000000);
    check_eq("allt_k48", bus.kmersOut[48], 32'h00000000);
`else
    check_eq("allt_k0", bus.kmersOut[0], 32'hFFFFFFFF);
    check_eq("allt_k48", bus.kmersOut[48], 32'hFFFFFFFF);
`endif
    check_array("allt");
    bus.kmersAck = 1'b1;
    bus.start    = 1'b1;
    tick();
    bus.kmersAck = 1'b0;
    bus.start    = 1'b0;
    check_eq("ackstart_state", 32'(dbg_state), 32'(IDLE));
    check_eq("ackstart_valid", 32'(bus.kmersValid), 32'd0);
    tick();
    check_eq("ackstart_state2", 32'(dbg_state), 32'(IDLE));
    check_eq("ackstart_busy", 32'(bus.busy), 32'd0);

    // all-A
    build_const(BASE_A);
    send_seq(SEQ_LEN, 0, -1, -1);
    check_eq("alla_k0", bus.kmersOut[0], 32'h00000000);
    check_array("alla");
    ack_done("alla");

    // reset after 30 accepts abandons the capture
    build_fwd();
    send_seq(30, 0, -1, -1);
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", 32'(bus.kmersValid), 32'd0);
    check_eq("midrst_kmers", 32'(|bus.kmersOut), 32'd0);
    check_eq("midrst_state", 32'(dbg_state), 32'(IDLE));
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    send_seq(SEQ_LEN, 1, -1, -1);
    check_array("post_rst");
    ack_done("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
